// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the image-RAM arbiter slice.
package ram_arbiter_pkg;

  localparam int ARB_N_REQ    = 4;
  localparam int RAM_RD_LAT   = 2;
  localparam int ARB_LOCK_MAX = 8;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin first-one finder: picks the first set request at or after i_start,
// wrapping, and returns it both one-hot and as an index.
module ram_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW:0]    w_off;
  logic [IW:0]    w_sum;
  logic           w_any;

  // Rotate so the start position sits at bit 0; the lowest set bit is then the winner.
  assign w_dbl = {i_req, i_req} >> i_start;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = (IW+1)'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_start} + w_off;
  assign o_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
  assign o_gnt = w_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port image RAM between the host loader (port 0, fixed priority)
// and round-robin engine ports, with burst lock and tagged read-return routing.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = RAM_RD_LAT,
  parameter int LOCK_MAX = ARB_LOCK_MAX
) (
  input  logic                    clk,
  input  logic                    aclr_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_wdata,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_lock_timeout,
  output logic                    o_ram_we,
  output logic [ADDR_W-1:0]       o_ram_addr,
  output logic [DATA_W-1:0]       o_ram_wdata,
  input  logic [DATA_W-1:0]       i_ram_rdata
);

  localparam int PW = clog2_min1(N_REQ);
  localparam int EW = clog2_min1(N_REQ - 1);
  localparam int CW = clog2_min1(LOCK_MAX);
  localparam logic [PW-1:0] LAST_ENG = PW'(N_REQ - 1);

  arb_state_t      r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_lock_cnt;
  logic            r_lock_timeout;
  logic [RD_LAT:0] r_tag_vld;
  logic [PW-1:0]   r_tag_port [RD_LAT+1];

  logic [N_REQ-2:0]  w_eng_gnt;
  logic [EW-1:0]     w_eng_idx;
  logic [EW-1:0]     w_rr_start;
  logic [N_REQ-1:0]  w_gnt;
  logic [PW-1:0]     w_acc_idx;
  logic              w_acc;
  logic              w_acc_we;
  logic              w_acc_lock;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_lock_release;
  logic              w_lock_expire;

  function automatic logic [PW-1:0] rr_after(input logic [PW-1:0] port);
    return (port == LAST_ENG) ? PW'(1) : port + PW'(1);
  endfunction

  assign w_rr_start = EW'(r_rr_ptr - PW'(1));

  ram_arbiter_rr_pick #(
    .N  (N_REQ - 1),
    .IW (EW)
  ) u_rr_pick (
    .i_req   (i_req[N_REQ-1:1]),
    .i_start (w_rr_start),
    .o_gnt   (w_eng_gnt),
    .o_idx   (w_eng_idx)
  );

  always_comb begin
    w_gnt     = '0;
    w_acc_idx = '0;
    if (!aclr_n) begin
      w_gnt = '0;
    end else if (r_state == LOCKED) begin
      w_gnt[r_owner] = i_req[r_owner];
      w_acc_idx      = r_owner;
    end else if (i_req[0]) begin
      w_gnt[0] = 1'b1;
    end else begin
      w_gnt[N_REQ-1:1] = w_eng_gnt;
      w_acc_idx        = PW'(w_eng_idx) + PW'(1);
    end
  end

  always_comb begin
    w_acc_we    = 1'b0;
    w_acc_lock  = 1'b0;
    w_acc_addr  = '0;
    w_acc_wdata = '0;
    for (int p = 0; p < N_REQ; p++) begin
      if (w_acc_idx == PW'(p)) begin
        w_acc_we    = i_we[p];
        w_acc_lock  = i_lock[p];
        w_acc_addr  = i_addr[p*ADDR_W +: ADDR_W];
        w_acc_wdata = i_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  assign w_acc = |w_gnt;
  // The owner's grant mirrors its request, so both release cases reduce to lock dropping.
  assign w_lock_release = ~i_lock[r_owner];
  assign w_lock_expire  = (r_lock_cnt == CW'(LOCK_MAX - 1));

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state        <= ARB;
      r_owner        <= '0;
      r_rr_ptr       <= PW'(1);
      r_lock_cnt     <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_acc) begin
            if (w_acc_idx != '0) r_rr_ptr <= rr_after(w_acc_idx);
            if (w_acc_lock) begin
              r_state    <= LOCKED;
              r_owner    <= w_acc_idx;
              r_lock_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          r_lock_cnt <= r_lock_cnt + CW'(1);
          if (w_lock_release || w_lock_expire) begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
            if (r_owner != '0) r_rr_ptr <= rr_after(r_owner);
            if (!w_lock_release) r_lock_timeout <= 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // RAM command stage: address/data hold when idle so the RAM sees stable inputs.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else begin
      o_ram_we <= w_acc & w_acc_we;
      if (w_acc) begin
        o_ram_addr  <= w_acc_addr;
        o_ram_wdata <= w_acc_wdata;
      end
    end
  end

  // Tag pipeline: tail lines up with the RAM's read data.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= RD_LAT; s++) r_tag_port[s] <= '0;
    end else begin
      r_tag_vld     <= {r_tag_vld[RD_LAT-1:0], w_acc & ~w_acc_we};
      r_tag_port[0] <= w_acc_idx;
      for (int s = 1; s <= RD_LAT; s++) r_tag_port[s] <= r_tag_port[s-1];
    end
  end

  always_comb begin
    o_rvalid = '0;
    o_rdata  = '0;
    if (r_tag_vld[RD_LAT]) begin
      o_rvalid[r_tag_port[RD_LAT]] = 1'b1;
      o_rdata                      = i_ram_rdata;
    end
  end

  assign o_gnt          = w_gnt;
  assign o_lock_timeout = r_lock_timeout;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port image RAM (16-bit address, 8-bit data, 2-cycle registered read) between the host loader and N parallel bilinear downscaling engines. Each requester has its own request/grant port. Port 0 (host) has fixed priority; engine ports rotate round-robin. An optional lock keeps a 4-neighbour fetch burst atomic. The arbiter registers the winning command onto the RAM and routes each read return to its originator through a tag pipeline.

## Interface
- N_REQ, 4: number of requesters; port 0 is host, ports 1..N_REQ-1 are engines (N_REQ ≥ 2)
- ADDR_W, 16: RAM address width
- DATA_W, 8: RAM data width
- RD_LAT, 2: cycles from ram_addr valid to ram_rdata valid
- LOCK_MAX, 8: maximum cycles a lock may be held
- clk  in  1  clock
- aclr_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-port command request
- we  in  N_REQ  per-port write enable (qualifies req)
- lock  in  N_REQ  per-port keep-ownership request
- addr  in  N_REQ×ADDR_W  per-port address (packed, port i at [i*ADDR_W +: ADDR_W])
- wdata  in  N_REQ×DATA_W  per-port write data
- gnt  out  N_REQ  one-hot (or zero) command accepted this cycle
- rvalid  out  N_REQ  one-hot read return strobe
- rdata  out  DATA_W  shared read data, valid with rvalid
- lock_timeout  out  1  sticky: a lock was force-released
- ram_we, ram_addr, ram_wdata  out  1/ADDR_W/DATA_W  registered RAM command
- ram_rdata  in  DATA_W  RAM read data

## Operation
- A command is accepted when req[i] & gnt[i] are high at a rising edge. gnt is combinational from req, lock state and the RR pointer. While aclr_n is low, gnt is forced to 0.
- FSM ARB:
  - If req[0]=1, grant port 0. The host wins any simultaneous contention.
  - Otherwise grant the first requesting engine at or after rr_ptr (range 1..N_REQ-1, wrapping).
  - After an accepted engine grant to port k, rr_ptr ← k+1, wrapping to 1. Host grants leave rr_ptr unchanged.
  - If the accepted command has lock[k]=1, go to LOCKED with owner←k and lock_cnt←0.
- FSM LOCKED:
  - Only the owner can be granted. All other ports see gnt=0, including the host.
  - lock_cnt increments every cycle.
  - Return to ARB at the edge where either:
    - the owner has an accepted command with lock=0 (last beat is still accepted), or
    - the owner has req=0 and lock=0.
  - If lock_cnt = LOCK_MAX-1 while still LOCKED, return to ARB and set lock_timeout. It stays set until reset.
  - rr_ptr updates past the owner on exit, as in ARB.
- Accepted command: at the edge, ram_we ← we[i], ram_addr ← addr[i], ram_wdata ← wdata[i]. With no accept, ram_we ← 0 and ram_addr/ram_wdata hold their values.
- Read tag pipeline (RD_LAT+1 entries of {valid, port}): an accepted read pushes {1,i}; writes and idle cycles push {0,x}. At the tail, rvalid[port] = valid and rdata = ram_rdata (pass-through). rvalid=0 gives rdata=0.
- Writes never produce rvalid.
- Reset values: gnt=0, rvalid=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, lock_timeout=0. FSM goes to ARB, rr_ptr=1, lock_cnt=0, tag pipeline is all invalid.
- Reset mid-operation: in-flight reads are discarded. No rvalid follows the reset release.

## Timing
- Request in cycle t, accepted at edge t. ram_addr is valid in cycle t+1 and ram_rdata in cycle t+1+RD_LAT. rvalid/rdata appear in the same cycle (t+3 for RD_LAT=2).
- Full throughput: one command per cycle from any mix of ports, with no bubbles.
- A single uncontended requester streaming 4 reads in t..t+3 receives rvalid in t+3..t+6, in issue order.
- A write accepted at t is visible to a read accepted at t+1 from any port (RAM read-after-write, single port).

## Structure
- formato_pkg gains ARB_N_REQ, RAM_RD_LAT and ARB_LOCK_MAX constants, plus the typedef arb_state_t {ARB, LOCKED}.
- Sub-module rr_pick is natural: a combinational round-robin first-one finder over N_REQ-1 engine bits with a start pointer, returning a one-hot grant and an index.
- Engines keep the control_unit's 4-neighbour read pattern. They drive lock=1 on beats 1–3 and lock=0 on beat 4.

## Test plan
- Single engine, port 1: reads to 0x0000, 0x0001, 0x0040, 0x0041 with lock=1,1,1,0 over 4 cycles. Required: gnt each cycle, rvalid[1] 3 cycles later with RAM contents in order, FSM back in ARB.
- Ports 1, 2 and 3 request continuously with no lock. Required: grants rotate 1→2→3→1, each port gets exactly 1/3 of cycles.
- Host plus engine: host requests while port 2 is mid-lock. Required: host gnt=0 until port 2's unlocked beat, then host granted next cycle. Without a lock, a simultaneous host/engine request grants the host.
- Lock abuse: port 3 holds req=1, lock=1 indefinitely. Required: forced release after LOCK_MAX cycles, lock_timeout=1, next grant goes to another requester.
- Host writes 0xA5 to 0x4000, then port 1 reads 0x4000 the next cycle. Required: rvalid[1] with rdata=0xA5, no rvalid for the write.
- Assert aclr_n low with 2 reads in flight. Required: all outputs return to 0 immediately, and no rvalid appears after release.
